trng_key_fetcher: RTL and testbench
===================================

// Module: trng_key_fetcher
// PURPOSE
//  Host-side initiator for the TRNG peripheral: drives its ctrl register port (reg_pkg) and its
//  OBI data port to enable the generator, detect key-ready, read 32-bit keys and acknowledge them.
//  Keys are buffered in a FIFO and handed to a local consumer (e.g. crypto core) over valid/ready,
//  so no CPU software is needed to harvest entropy.
// PARAMETERS
//  FIFO_DEPTH     4       keys buffered; power of two, >=2
//  POLL_INTERVAL  64      cycles between status polls when trng_intr_i stays low; >=1
//  CTRL_ADDR      32'h0   ctrl reg offset: bit0 = ack_read, bit2 = enable
//  STATUS_ADDR    32'h4   status reg offset: bit0 = key ready
//  DATA_ADDR      32'h0   OBI address of the key word
// PORTS
//  clk_i        in   1      clock
//  rst_i        in   1      synchronous reset, active-high
//  start_i      in   1      level: 1 = harvest keys, 0 = shut TRNG down
//  trng_intr_i  in   1      TRNG interrupt; poll hint only
//  reg_req_o    out  reg_req_t   ctrl-port request (valid/write/addr/wdata/wstrb)
//  reg_rsp_i    in   reg_rsp_t   ctrl-port response (ready/rdata/error)
//  obi_req_o    out  obi_req_t   data-port request (req/we/be/addr/wdata)
//  obi_resp_i   in   obi_resp_t  data-port response (gnt/rvalid/rdata)
//  key_o        out  32     key at FIFO head
//  key_valid_o  out  1      FIFO not empty
//  key_ready_i  in   1      consumer pop; key_valid_o & key_ready_i pops one entry
//  busy_o       out  1      FSM not in IDLE
//  err_o        out  1      sticky: any reg_rsp_i.error seen; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM IDLE, poll timer 0. Reset also abandons an in-flight
//    OBI/reg transfer; system resets TRNG in same cycle.
//  - Reg transfers: reg_req_o.valid held with stable fields until reg_rsp_i.ready; one at a time;
//    write = 1 for writes, wstrb 4'hF. OBI: req held until gnt; we=0, be=4'hF; then wait rvalid.
//    Never more than one outstanding OBI read.
//  - FSM: IDLE -(start_i)-> EN_WR (write CTRL=0x4) -> WAIT
//    WAIT: if !start_i -> DIS_WR; elif FIFO full -> stay (timer frozen);
//          elif trng_intr_i or timer==POLL_INTERVAL-1 -> POLL (timer cleared)
//    POLL: read STATUS; bit0=1 -> FETCH, else -> WAIT
//    FETCH: OBI req until gnt -> RDATA: on rvalid push rdata into FIFO -> ACK_SET
//    ACK_SET: write CTRL=0x5 -> ACK_CLR: write CTRL=0x4 -> WAIT
//    DIS_WR: write CTRL=0x0 -> IDLE
//  - start_i falling mid-sequence: POLL/FETCH/RDATA/ACK_* complete (key pushed and acked) before
//    WAIT branches to DIS_WR; no transfer is ever aborted.
//  - FIFO full gate guarantees a slot at push time; push never dropped. Simultaneous push and
//    pop legal at any fill level including full-with-pop (count unchanged).
//  - FIFO pointers wrap mod FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1. key_o is registered
//    FIFO head; a key pushed into empty FIFO is valid the cycle after rvalid.
//  - Reg error response: err_o set, transfer treated as complete, FSM proceeds (POLL with error
//    counts as not-ready).
//  - Minimum key latency from WAIT with intr high: POLL(>=1)+FETCH(>=1)+RDATA(>=1) cycles.
//  - FIFO contents survive start_i=0; consumer may drain after shutdown.
// STRUCTURE
//  - trng_fetcher_pkg: fetch_state_e enum, CTRL_ENABLE/CTRL_ACK bit indices, CTRL word constants
//    (0x0/0x4/0x5), STATUS_READY bit index.
//  - Sub-module trng_key_fifo (sync FIFO, DEPTH/WIDTH params, push/pop/full/empty/head).
//  - Top: FSM, poll timer, bus request registers, err flag.
// TESTING
//  1 Reset then start_i=1, TRNG model ready after 10 cycles with key 0xA5A5_1234 -> reg writes
//    0x4, poll, OBI read, writes 0x5 then 0x4; key_o=0xA5A5_1234, key_valid_o=1.
//  2 key_ready_i=0, 5 keys produced, FIFO_DEPTH=4 -> 4 keys buffered, no 5th OBI req while full;
//    one pop -> 5th key fetched, order preserved.
//  3 trng_intr_i tied 0, POLL_INTERVAL=64 -> STATUS reads exactly every 64 WAIT cycles plus
//    transfer time; key still harvested.
//  4 start_i dropped while OBI gnt pending with random gnt/rvalid/ready stalls 0-7 cycles ->
//    key pushed, ack pair written, then CTRL=0x0, busy_o falls; fields stable during stalls.
//  5 reg_rsp_i.error on STATUS read -> err_o=1 sticky, FSM returns to WAIT, next poll proceeds.
//  6 rst_i asserted in RDATA -> next cycle all outputs 0, FIFO empty, FSM IDLE.

Source files
------------

// File: rtl/trng_fetcher_pkg.sv
// Shared types and constants for the TRNG key fetcher: FSM states, the ctrl-port and
// OBI request/response structs, and the control words written to the TRNG.
package trng_fetcher_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_EN_WR   = 4'd1,
    ST_WAIT    = 4'd2,
    ST_POLL    = 4'd3,
    ST_FETCH   = 4'd4,
    ST_RDATA   = 4'd5,
    ST_ACK_SET = 4'd6,
    ST_ACK_CLR = 4'd7,
    ST_DIS_WR  = 4'd8
  } fetch_state_e;

  localparam int CTRL_ACK     = 0;
  localparam int CTRL_ENABLE  = 2;
  localparam int STATUS_READY = 0;

  localparam logic [31:0] CTRL_WORD_OFF = 32'h0000_0000;
  localparam logic [31:0] CTRL_WORD_EN  = 32'h0000_0004;
  localparam logic [31:0] CTRL_WORD_ACK = 32'h0000_0005;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  function automatic reg_req_t reg_write(input logic [31:0] addr, input logic [31:0] data);
    reg_req_t r;
    r.valid = 1'b1;
    r.write = 1'b1;
    r.addr  = addr;
    r.wdata = data;
    r.wstrb = 4'hF;
    return r;
  endfunction

  function automatic reg_req_t reg_read(input logic [31:0] addr);
    reg_req_t r;
    r.valid = 1'b1;
    r.write = 1'b0;
    r.addr  = addr;
    r.wdata = 32'h0000_0000;
    r.wstrb = 4'h0;
    return r;
  endfunction

endpackage

// File: rtl/trng_key_fifo.sv
// Synchronous key FIFO with a registered head word; a push into an empty FIFO is visible
// on head_o/valid_o the following cycle.
module trng_key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_d;
  logic             valid;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop_i && (count != '0);
  assign push_ok = push_i && ((count != CW'(DEPTH)) || pop_ok);

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign head_o  = head;
  assign valid_o = valid;

  // Next fill level and next head word.
  always_comb begin
    count_d = count;
    head_d  = head;
    if (push_ok && !pop_ok) begin
      count_d = count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count - CW'(1);
    end else begin
      count_d = count;
    end
    // The word after the head comes from memory unless the popped head was the only entry.
    if (pop_ok) begin
      if (count > CW'(1)) begin
        head_d = mem[rptr + PW'(1)];
      end else if (push_ok) begin
        head_d = push_data_i;
      end else begin
        head_d = '0;
      end
    end else if (push_ok && (count == '0)) begin
      head_d = push_data_i;
    end else begin
      head_d = head;
    end
  end

  // Storage array; contents need no reset since valid/count gate every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wptr] <= push_data_i;
    end
  end

  // Pointers, count and registered head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      head  <= '0;
      valid <= 1'b0;
    end else begin
      wptr  <= wptr + PW'(push_ok);
      rptr  <= rptr + PW'(pop_ok);
      count <= count_d;
      head  <= head_d;
      valid <= (count_d != '0);
    end
  end

endmodule

// File: rtl/trng_key_fetcher.sv
// Autonomous TRNG harvester: enables the TRNG over its ctrl port, polls status, reads keys over
// OBI, acknowledges them and buffers them in a FIFO for a local valid/ready consumer.
module trng_key_fetcher
  import trng_fetcher_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned POLL_INTERVAL = 64,
  parameter logic [31:0] CTRL_ADDR     = 32'h0000_0000,
  parameter logic [31:0] STATUS_ADDR   = 32'h0000_0004,
  parameter logic [31:0] DATA_ADDR     = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        trng_intr_i,
  output reg_req_t    reg_req_o,
  input  reg_rsp_t    reg_rsp_i,
  output obi_req_t    obi_req_o,
  input  obi_resp_t   obi_resp_i,
  output logic [31:0] key_o,
  output logic        key_valid_o,
  input  logic        key_ready_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int TIMER_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_INTERVAL - 1);

  fetch_state_e     state;
  fetch_state_e     state_d;
  logic [TIMER_W-1:0] timer;
  reg_req_t         reg_req;
  reg_req_t         reg_req_d;
  obi_req_t         obi_req;
  obi_req_t         obi_req_d;
  logic             busy;
  logic             err;
  logic             poll_due;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             unused_bits;

  assign poll_due    = trng_intr_i || (timer == TIMER_LAST);
  assign push        = (state == ST_RDATA) && obi_resp_i.rvalid;
  assign pop         = key_valid_o && key_ready_i;
  assign reg_req_o   = reg_req;
  assign obi_req_o   = obi_req;
  assign busy_o      = busy;
  assign err_o       = err;
  assign unused_bits = ^{reg_rsp_i.rdata, fifo_empty};

  // Next-state logic; every bus state advances only on its handshake.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (start_i) state_d = ST_EN_WR; else state_d = ST_IDLE;
      ST_EN_WR:   if (reg_rsp_i.ready) state_d = ST_WAIT; else state_d = ST_EN_WR;
      ST_WAIT: begin
        if (!start_i) begin
          state_d = ST_DIS_WR;
        end else if (fifo_full) begin
          state_d = ST_WAIT;
        end else if (poll_due) begin
          state_d = ST_POLL;
        end else begin
          state_d = ST_WAIT;
        end
      end
      // An error response is treated as "not ready".
      ST_POLL: begin
        if (!reg_rsp_i.ready) begin
          state_d = ST_POLL;
        end else if (!reg_rsp_i.error && reg_rsp_i.rdata[STATUS_READY]) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FETCH:   if (obi_resp_i.gnt) state_d = ST_RDATA; else state_d = ST_FETCH;
      ST_RDATA:   if (obi_resp_i.rvalid) state_d = ST_ACK_SET; else state_d = ST_RDATA;
      ST_ACK_SET: if (reg_rsp_i.ready) state_d = ST_ACK_CLR; else state_d = ST_ACK_SET;
      ST_ACK_CLR: if (reg_rsp_i.ready) state_d = ST_WAIT; else state_d = ST_ACK_CLR;
      ST_DIS_WR:  if (reg_rsp_i.ready) state_d = ST_IDLE; else state_d = ST_DIS_WR;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus requests decoded from the next state so they are registered yet present on state entry.
  always_comb begin
    reg_req_d = '0;
    obi_req_d = '0;
    case (state_d)
      ST_EN_WR:   reg_req_d = reg_write(CTRL_ADDR, CTRL_WORD_EN);
      ST_POLL:    reg_req_d = reg_read(STATUS_ADDR);
      ST_ACK_SET: reg_req_d = reg_write(CTRL_ADDR, CTRL_WORD_ACK);
      ST_ACK_CLR: reg_req_d = reg_write(CTRL_ADDR, CTRL_WORD_EN);
      ST_DIS_WR:  reg_req_d = reg_write(CTRL_ADDR, CTRL_WORD_OFF);
      ST_FETCH: begin
        obi_req_d.req   = 1'b1;
        obi_req_d.we    = 1'b0;
        obi_req_d.be    = 4'hF;
        obi_req_d.addr  = DATA_ADDR;
        obi_req_d.wdata = 32'h0000_0000;
      end
      default: begin
        reg_req_d = '0;
        obi_req_d = '0;
      end
    endcase
  end

  // State, request registers, busy flag and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      reg_req <= '0;
      obi_req <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      reg_req <= reg_req_d;
      obi_req <= obi_req_d;
      busy    <= (state_d != ST_IDLE);
      if (reg_req.valid && reg_rsp_i.ready && reg_rsp_i.error) begin
        err <= 1'b1;
      end
    end
  end

  // Poll timer counts WAIT cycles; frozen while the FIFO is full, zero outside WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer <= '0;
    end else if (state != ST_WAIT) begin
      timer <= '0;
    end else if (start_i && !fifo_full) begin
      if (poll_due) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

  trng_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (obi_resp_i.rdata),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (key_o),
    .valid_o     (key_valid_o)
  );

endmodule

// File: tb/tb_trng_key_fetcher.sv
// Self-checking bench: a behavioural TRNG/bus model answers the fetcher's transfers with random
// stalls, and every key delivered to the consumer is checked against the keys the model served.
module tb_trng_key_fetcher;
  import trng_fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        trng_intr;
  reg_req_t    reg_req;
  reg_rsp_t    reg_rsp;
  obi_req_t    obi_req;
  obi_resp_t   obi_rsp;
  logic [31:0] key;
  logic        key_valid;
  logic        key_ready;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // TRNG model state and test knobs
  logic        trng_en = 1'b0;
  logic        trng_rdy = 1'b0;
  int          trng_cnt = 0;
  int          trng_delay = 10;
  logic [31:0] trng_key = 32'h0;
  logic        use_fixed = 1'b0;
  logic        intr_mode = 1'b1;
  logic        inject_err = 1'b0;
  logic        long_rv = 1'b0;
  int          max_stall = 0;
  int          pop_budget = 0;
  int          obi_served = 0;
  int          status_cnt = 0;
  int          err_obi = 0;
  int          err_status = 0;
  logic        obi_pending = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];
  int          status_t[$];

  trng_key_fetcher #(
    .FIFO_DEPTH(4), .POLL_INTERVAL(64),
    .CTRL_ADDR(32'h0), .STATUS_ADDR(32'h4), .DATA_ADDR(32'h0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .trng_intr_i(trng_intr),
    .reg_req_o(reg_req), .reg_rsp_i(reg_rsp), .obi_req_o(obi_req), .obi_resp_i(obi_rsp),
    .key_o(key), .key_valid_o(key_valid), .key_ready_i(key_ready),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ctrl-port responder plus the TRNG generator itself.
  initial begin : reg_side
    int stall; logic pend; reg_req_t last; int first_cyc;
    stall = 0; pend = 1'b0; last = '0; first_cyc = 0;
    reg_rsp = '0; trng_intr = 1'b0;
    forever begin
      @(negedge clk);
      reg_rsp = '0;
      if (rst) begin
        trng_en = 1'b0; trng_rdy = 1'b0; pend = 1'b0; stall = 0; trng_intr = 1'b0;
        continue;
      end
      if (trng_en && !trng_rdy) begin
        if (trng_cnt == 0) begin
          trng_rdy = 1'b1;
          trng_key = use_fixed ? 32'hA5A5_1234 : $urandom;
          use_fixed = 1'b0;
        end else trng_cnt--;
      end
      if (reg_req.valid) begin
        if (pend) chk("reg_stable", reg_req, last);
        else first_cyc = cycle;
        if (stall > 0) begin
          stall--; pend = 1'b1; last = reg_req;
        end else begin
          reg_rsp.ready = 1'b1;
          if (reg_req.write) begin
            chk("reg_wr_fields", {reg_req.addr, reg_req.wstrb}, {32'h0, 4'hF});
            wr_log.push_back(reg_req.wdata);
            if (reg_req.wdata[0] && trng_rdy) begin trng_rdy = 1'b0; trng_cnt = trng_delay; end
            if (reg_req.wdata[2] && !trng_en) trng_cnt = trng_delay;
            trng_en = reg_req.wdata[2];
            if (!trng_en) trng_rdy = 1'b0;
          end else begin
            chk("reg_rd_addr", reg_req.addr, 32'h4);
            status_t.push_back(first_cyc);
            status_cnt++;
            reg_rsp.rdata = {31'h0, trng_rdy};
            if (inject_err && trng_rdy) begin
              reg_rsp.error = 1'b1; inject_err = 1'b0;
              err_obi = obi_served; err_status = status_cnt;
            end
          end
          pend = 1'b0;
          stall = $urandom_range(max_stall, 0);
        end
      end else pend = 1'b0;
      trng_intr = intr_mode && trng_rdy;
    end
  end

  // OBI responder: grant after a random stall, then return the current TRNG key.
  initial begin : obi_side
    int gstall; int rstall; logic pend; obi_req_t last;
    gstall = 0; rstall = 0; pend = 1'b0; last = '0;
    obi_rsp = '0;
    forever begin
      @(negedge clk);
      obi_rsp = '0;
      if (rst) begin
        obi_pending = 1'b0; pend = 1'b0; gstall = 0; exp_q.delete();
        continue;
      end
      if (obi_pending) begin
        chk("obi_single_outstanding", obi_req.req, 1'b0);
        if (rstall > 0) rstall--;
        else begin
          obi_rsp.rvalid = 1'b1; obi_rsp.rdata = trng_key;
          exp_q.push_back(trng_key); obi_served++; obi_pending = 1'b0;
        end
      end else if (obi_req.req) begin
        if (pend) chk("obi_stable", obi_req, last);
        chk("obi_we_be_addr", {obi_req.we, obi_req.be, obi_req.addr}, {1'b0, 4'hF, 32'h0});
        if (gstall > 0) begin
          gstall--; pend = 1'b1; last = obi_req;
        end else begin
          obi_rsp.gnt = 1'b1; pend = 1'b0; obi_pending = 1'b1;
          rstall = long_rv ? 20 : $urandom_range(max_stall, 0);
          gstall = $urandom_range(max_stall, 0);
        end
      end else pend = 1'b0;
    end
  end

  // Consumer: pops within a budget and checks order against the served keys.
  initial begin : consumer
    key_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || pop_budget == 0) key_ready = 1'b0;
      else begin
        key_ready = (max_stall == 0) || ($urandom_range(1, 0) == 1);
        if (key_ready && key_valid) begin
          if (exp_q.size() == 0) chk("pop_without_key", 1'b1, 1'b0);
          else chk("pop_key_order", key, exp_q.pop_front());
          pop_budget--;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic stop_and_drain(input string tag);
    start = 1'b0;
    pop_budget = 1000;
    for (int i = 0; i < 3000 && (busy || key_valid || exp_q.size() != 0); i++) @(negedge clk);
    chk({tag, "_drained"}, {busy, key_valid, 1'b0 + (exp_q.size() != 0)}, 3'b000);
    pop_budget = 0;
  endtask

  initial begin : main
    int base_log; int base_obi;
    logic any_req;
    rst = 1'b1; start = 1'b0;
    wait_cycles(3);
    chk("reset_reg_req", reg_req, '0);
    chk("reset_obi_req", obi_req, '0);
    chk("reset_outputs", {key, key_valid, busy, err}, 35'h0);
    rst = 1'b0;

    // 1: first key with fixed value, full ctrl sequence
    wr_log.delete(); use_fixed = 1'b1; trng_delay = 10; intr_mode = 1'b1; max_stall = 0;
    start = 1'b1;
    for (int i = 0; i < 300 && !key_valid; i++) @(negedge clk);
    chk("t1_key_valid", key_valid, 1'b1);
    chk("t1_key_value", key, 32'hA5A5_1234);
    chk("t1_busy", busy, 1'b1);
    for (int i = 0; i < 100 && wr_log.size() < 3; i++) @(negedge clk);
    chk("t1_wr_count", wr_log.size(), 3);
    chk("t1_wr_seq", {wr_log[0], wr_log[1], wr_log[2]}, {32'h4, 32'h5, 32'h4});
    stop_and_drain("t1");

    // 2: FIFO fills, no fetch while full, one pop releases the fifth key
    trng_delay = 2; max_stall = 3; base_obi = obi_served;
    start = 1'b1;
    for (int i = 0; i < 2000 && obi_served < base_obi + 4; i++) @(negedge clk);
    chk("t2_four_served", obi_served - base_obi, 4);
    any_req = 1'b0;
    for (int i = 0; i < 150; i++) begin @(negedge clk); any_req |= obi_req.req; end
    chk("t2_no_req_when_full", {any_req, 1'b0 + (obi_served - base_obi == 4)}, 2'b01);
    chk("t2_head_is_first", key, exp_q[0]);
    pop_budget = 1;
    for (int i = 0; i < 500 && obi_served < base_obi + 5; i++) @(negedge clk);
    chk("t2_fifth_served", obi_served - base_obi, 5);
    stop_and_drain("t2");

    // 3: no interrupt, polling period is 64 WAIT cycles plus a 1-cycle read
    intr_mode = 1'b0; max_stall = 0; trng_delay = 300; status_t.delete();
    base_obi = obi_served; pop_budget = 1000;
    start = 1'b1;
    for (int i = 0; i < 600 && status_t.size() < 3; i++) @(negedge clk);
    chk("t3_polls_seen", 1'b0 + (status_t.size() >= 3), 1'b1);
    if (status_t.size() >= 3) begin
      chk("t3_period_a", status_t[1] - status_t[0], 65);
      chk("t3_period_b", status_t[2] - status_t[1], 65);
    end
    for (int i = 0; i < 1000 && obi_served == base_obi; i++) @(negedge clk);
    chk("t3_key_harvested", obi_served - base_obi, 1);
    stop_and_drain("t3");

    // 4: drop start while the OBI request is pending under random stalls
    intr_mode = 1'b1; max_stall = 7; trng_delay = 3; pop_budget = 1000;
    start = 1'b1;
    for (int i = 0; i < 500 && !obi_req.req; i++) @(negedge clk);
    chk("t4_req_seen", obi_req.req, 1'b1);
    base_log = wr_log.size(); base_obi = obi_served;
    start = 1'b0;
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    chk("t4_busy_fell", busy, 1'b0);
    chk("t4_key_pushed", obi_served - base_obi, 1);
    chk("t4_wr_count", wr_log.size() - base_log, 3);
    if (wr_log.size() >= base_log + 3)
      chk("t4_wr_seq", {wr_log[base_log], wr_log[base_log+1], wr_log[base_log+2]},
          {32'h5, 32'h4, 32'h0});
    stop_and_drain("t4");

    // 5: error on a ready STATUS read is sticky and treated as not-ready
    max_stall = 0; trng_delay = 5; inject_err = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 500 && !err; i++) @(negedge clk);
    chk("t5_err_set", err, 1'b1);
    for (int i = 0; i < 500 && status_cnt <= err_status; i++) @(negedge clk);
    chk("t5_repoll", 1'b0 + (status_cnt > err_status), 1'b1);
    chk("t5_no_fetch_on_err", obi_served - err_obi, 0);
    for (int i = 0; i < 500 && obi_served == err_obi; i++) @(negedge clk);
    chk("t5_key_after_err", 1'b0 + (obi_served > err_obi), 1'b1);
    chk("t5_err_sticky", err, 1'b1);

    // 6: reset while waiting for rvalid
    long_rv = 1'b1;
    for (int i = 0; i < 500 && !obi_pending; i++) @(negedge clk);
    chk("t6_in_rdata", obi_pending, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_reg_req", reg_req, '0);
    chk("t6_obi_req", obi_req, '0);
    chk("t6_outputs", {key, key_valid, busy, err}, 35'h0);
    rst = 1'b0; start = 1'b0; long_rv = 1'b0;
    wait_cycles(5);
    chk("t6_idle_after", {key_valid, busy, err, reg_req.valid, obi_req.req}, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
